tm1638_hex_scanner: RTL
=======================

Name: tm1638_hex_scanner

Overview:
- Upstream feeder for tm1638_board_controller: converts a packed hex value plus a dot mask into the time-multiplexed abcdefgh / one-hot digit stream the controller consumes.
- Double-buffers display data and commits new data only at a frame boundary, so a digit never shows a mix of old and new values.
- Optionally suppresses leading zeros.

Parameters:
- clk_mhz, 27, clock frequency in MHz.
- w_digit, 8, number of digits; must be >= 2.
- digit_us, 1000, dwell time per digit in microseconds; P = clk_mhz * digit_us clock cycles per digit, P >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- value  input  4*w_digit  hex nibbles; nibble i drives digit i; nibble w_digit-1 is the most significant.
- dots  input  w_digit  decimal point per digit; bit i drives digit i.
- lz_blank  input  1  leading-zero suppression enable.
- load  input  1  one-cycle strobe; stages value, dots and lz_blank.
- pending  output  1  staged data is waiting for the next frame boundary.
- abcdefgh  output  8  active-high segments; bit7 = a ... bit1 = g, bit0 = h (dot).
- digit  output  w_digit  one-hot active digit, active-high.
- frame_start  output  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Clock and reset: the block uses one clock, clk. Reset rst is synchronous and active-high.
- Reset values: abcdefgh = 0, digit = 0, frame_start = 0, pending = 0. Internally, dwell counter = 0, index = w_digit-1, and the staged and committed registers are cleared.
- Reset asserted mid-frame or mid-load discards all staged and committed data.
- All outputs are registered.
- Dwell counter: counts 0..P-1 and wraps. The cycle where counter = P-1 is a tick.
- Index advance: on a tick, the index advances as idx+1, wrapping from w_digit-1 to 0.
- Output update: in the cycle after a tick (tick+1), digit = 1 << idx_new and abcdefgh = font(committed nibble idx_new) | dot.
- Hold between ticks: digit and abcdefgh hold their values.
- First tick after reset: the index wraps to 0, so digit 0 with committed data appears P cycles after reset deasserts.
- Frame boundary: a tick whose new index is 0. At tick+1, frame_start = 1 for exactly one cycle.
- Staging: if load is asserted on a cycle that is not a frame boundary, the inputs are copied into the staged registers and pending = 1 from the next cycle. A repeated load while pending overwrites the staged data (latest wins).
- Commit: at a frame boundary with pending = 1, staged data is copied to the committed registers and pending returns to 0. Digit 0 of that frame already shows the new data.
- load coinciding with a frame boundary: the inputs bypass staging and commit directly; pending = 0 afterwards. This holds regardless of any earlier staged data, which is discarded.
- Stability: committed data never changes except at a frame boundary.
- Font (hex to abcdefgh, dot bit 0): 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE b:3E C:9C d:7A E:9E F:8E.
- Leading-zero suppression: when committed lz_blank = 1, digit i's segments a..g are blanked if nibbles w_digit-1 down to i are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Dots on blanked digits: still displayed; bit0 follows dots[i] regardless of blanking.
- Digit drive: digit stays one-hot at all times after the first tick. Blanking never removes the digit strobe.

Test Plan:
1. Setup and reset: use clk_mhz=1, digit_us=4 (P=4); hold rst for 3 cycles, then release. Required: outputs stay 0 for 3 cycles, then at cycle 4 digit=0x01, abcdefgh=0xFC, frame_start=1 for one cycle.
2. Commit at frame boundary: load value=0x01234567, dots=0, lz_blank=0 mid-frame. Required: pending=1 until the next frame_start. The next frame shows digit0=E0 (7), digit1=BE (6), ... digit7=FC (0), each for 4 cycles, and pending=0.
3. Leading-zero suppression: load value=0x000000A0, lz_blank=1, dots=0x80. Required: digits 7..2 show 0x00 except digit7=0x01; digit1=0xEE; digit0=0xFC.
4. Double load and coincident load: two loads within one frame (0x11111111 then 0x22222222). Required: only 0x22222222 is committed and digit0=0xDA. Then a load coinciding with a frame-boundary tick. Required: committed immediately, pending stays 0.
5. Reset mid-frame: assert rst at idx=3 with pending=1. Required: next cycle all outputs are 0 and pending=0; after release, a blank "0" frame (0xFC on digit 0) resumes at cycle P.
6. Index wrap and strobe check: run 3 full frames. Required: digit sequence 01,02,04,...,80,01 with no gaps; frame_start occurs every 32 cycles; digit is one-hot on every cycle.

Source files
------------

// File: rtl/tm1638_hex_scanner_if.sv
// Display-data bus between a hex source and tm1638_hex_scanner: staging inputs
// in one direction, the scanned segment/digit stream in the other.
interface tm1638_hex_scanner_if #(
    parameter int w_digit = 8
);
    logic [4*w_digit-1:0] value;
    logic [w_digit-1:0]   dots;
    logic                 lz_blank;
    logic                 load;
    logic                 pending;
    logic [7:0]           abcdefgh;
    logic [w_digit-1:0]   digit;
    logic                 frame_start;

    modport master (
        output value, dots, lz_blank, load,
        input  pending, abcdefgh, digit, frame_start
    );

    modport slave (
        input  value, dots, lz_blank, load,
        output pending, abcdefgh, digit, frame_start
    );
endinterface

// File: rtl/tm1638_hex_scanner.sv
// Time-multiplexed hex display scanner with frame-aligned double buffering and
// optional leading-zero suppression; feeds tm1638_board_controller.
module tm1638_hex_scanner #(
    parameter int clk_mhz  = 27,
    parameter int w_digit  = 8,
    parameter int digit_us = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    tm1638_hex_scanner_if.slave   bus
);
    localparam int P  = clk_mhz * digit_us;
    localparam int CW = $clog2(P);
    localparam int IW = $clog2(w_digit);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*w_digit-1:0]   stg_val_q, stg_val_d, com_val_q, com_val_d;
    logic [w_digit-1:0]     stg_dots_q, stg_dots_d, com_dots_q, com_dots_d;
    logic                   stg_lz_q, stg_lz_d, com_lz_q, com_lz_d;
    logic                   pending_q, pending_d;
    logic [7:0]             seg_q, seg_d;
    logic [w_digit-1:0]     digit_q, digit_d;
    logic                   fs_q, fs_d;
    logic                   tick, boundary, zero_run, blank;
    logic [w_digit-1:0]     lead_zero;

    function automatic logic [7:0] font(input logic [3:0] nib);
        case (nib)
            4'h0: font = 8'hFC;  4'h1: font = 8'h60;  4'h2: font = 8'hDA;  4'h3: font = 8'hF2;
            4'h4: font = 8'h66;  4'h5: font = 8'hB6;  4'h6: font = 8'hBE;  4'h7: font = 8'hE0;
            4'h8: font = 8'hFE;  4'h9: font = 8'hF6;  4'hA: font = 8'hEE;  4'hB: font = 8'h3E;
            4'hC: font = 8'h9C;  4'hD: font = 8'h7A;  4'hE: font = 8'h9E;  default: font = 8'h8E;
        endcase
    endfunction

    always_comb begin
        tick     = (cnt_q == CW'(P - 1));
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        if (tick)
            idx_d = (idx_q == IW'(w_digit - 1)) ? '0 : idx_q + IW'(1);
        boundary = tick && (idx_d == '0);

        stg_val_d  = stg_val_q;
        stg_dots_d = stg_dots_q;
        stg_lz_d   = stg_lz_q;
        com_val_d  = com_val_q;
        com_dots_d = com_dots_q;
        com_lz_d   = com_lz_q;
        pending_d  = pending_q;

        // A load landing on the boundary itself skips staging and wins over older staged data.
        if (boundary) begin
            pending_d = 1'b0;
            if (bus.load) begin
                com_val_d  = bus.value;
                com_dots_d = bus.dots;
                com_lz_d   = bus.lz_blank;
            end else if (pending_q) begin
                com_val_d  = stg_val_q;
                com_dots_d = stg_dots_q;
                com_lz_d   = stg_lz_q;
            end
        end else if (bus.load) begin
            stg_val_d  = bus.value;
            stg_dots_d = bus.dots;
            stg_lz_d   = bus.lz_blank;
            pending_d  = 1'b1;
        end

        zero_run = 1'b1;
        for (int i = w_digit - 1; i >= 0; i--) begin
            zero_run     = zero_run & (com_val_d[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_run;
        end
        blank = com_lz_d && lead_zero[idx_d] && (idx_d != '0);

        // Segments are built from the post-commit data so digit 0 of a new frame is already fresh.
        seg_d   = seg_q;
        digit_d = digit_q;
        fs_d    = 1'b0;
        if (tick) begin
            digit_d  = {{(w_digit-1){1'b0}}, 1'b1} << idx_d;
            seg_d    = blank ? 8'h00 : font(com_val_d[4*idx_d +: 4]);
            seg_d[0] = com_dots_d[idx_d];
            fs_d     = boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= IW'(w_digit - 1);
            stg_val_q  <= '0;
            stg_dots_q <= '0;
            stg_lz_q   <= 1'b0;
            com_val_q  <= '0;
            com_dots_q <= '0;
            com_lz_q   <= 1'b0;
            pending_q  <= 1'b0;
            seg_q      <= '0;
            digit_q    <= '0;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stg_val_q  <= stg_val_d;
            stg_dots_q <= stg_dots_d;
            stg_lz_q   <= stg_lz_d;
            com_val_q  <= com_val_d;
            com_dots_q <= com_dots_d;
            com_lz_q   <= com_lz_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.abcdefgh    = seg_q;
    assign bus.digit       = digit_q;
    assign bus.frame_start = fs_q;
endmodule
